// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: pops IN_WIDTH-bit words from an FWFT FIFO head and
// serialises each one into IN_WIDTH/OUT_WIDTH beats on a valid/ready stream.
// A new word is popped in the same cycle as the last-beat handshake, so an
// always-ready sink sees no idle cycle between words.
module fifo_word_unpacker #(
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   output logic                 fifo_rd_en,
   input  logic [IN_WIDTH-1:0]  fifo_rd_data,
   input  logic                 fifo_empty,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_first,
   output logic                 out_last,
   output logic [15:0]          word_cnt
);

   localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   logic                run;
   logic                hold_valid;
   logic [IN_WIDTH-1:0] hold_data;
   logic [IDX_W-1:0]    beat_idx;
   logic [IDX_W-1:0]    slice_k;
   logic                bh;
   logic                wend;

   assign bh   = hold_valid & out_ready;
   assign wend = bh & (beat_idx == LAST_IDX);

   // run gates the pop so the FIFO is never read in the cycle reset releases.
   assign fifo_rd_en = run & ~flush & ~fifo_empty & (~hold_valid | wend);

   assign out_valid = hold_valid;
   assign out_first = hold_valid & (beat_idx == '0);
   assign out_last  = hold_valid & (beat_idx == LAST_IDX);

   // Pick the slice for the current beat according to the beat order.
   always_comb begin
      slice_k  = MSB_FIRST ? (LAST_IDX - beat_idx) : beat_idx;
      out_data = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (slice_k == IDX_W'(k)) begin
            out_data = hold_data[k*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   // Enable pops from the first edge after reset release onwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // Word holding register and beat pointer; flush beats every other event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         beat_idx   <= '0;
      end else if (flush) begin
         hold_valid <= 1'b0;
         beat_idx   <= '0;
      end else if (fifo_rd_en) begin
         hold_valid <= 1'b1;
         hold_data  <= fifo_rd_data;
         beat_idx   <= '0;
      end else if (wend) begin
         hold_valid <= 1'b0;
         beat_idx   <= '0;
      end else if (bh) begin
         beat_idx <= beat_idx + IDX_W'(1);
      end
   end

   // Count fully emitted words; a word ending under flush is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (wend && !flush) begin
         word_cnt <= word_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench: two unpackers (LSB-first and MSB-first), each fed by its own
// queue-modelled FWFT FIFO, with shared clock, reset, flush and ready.
module tb_fifo_word_unpacker;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        out_ready;

   logic        rd0, rd1;
   logic [31:0] fdata0, fdata1;
   logic        fempty0, fempty1;
   logic        v0, v1, f0, f1, l0, l1;
   logic [7:0]  d0, d1;
   logic [15:0] wc0, wc1;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   int total = 0;
   int bad   = 0;

   fifo_word_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fifo_rd_en(rd0), .fifo_rd_data(fdata0), .fifo_empty(fempty0),
      .out_valid(v0), .out_ready(out_ready), .out_data(d0),
      .out_first(f0), .out_last(l0), .word_cnt(wc0)
   );

   fifo_word_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fifo_rd_en(rd1), .fifo_rd_data(fdata1), .fifo_empty(fempty1),
      .out_valid(v1), .out_ready(out_ready), .out_data(d1),
      .out_first(f1), .out_last(l1), .word_cnt(wc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat0(input string tag, input logic v, input logic [7:0] d,
                            input logic f, input logic l);
      chk({tag, ".valid"}, 32'(v0), 32'(v));
      chk({tag, ".data"},  32'(d0), 32'(d));
      chk({tag, ".first"}, 32'(f0), 32'(f));
      chk({tag, ".last"},  32'(l0), 32'(l));
   endtask

   task automatic push0(input logic [31:0] w);
      q0.push_back(w);
      fempty0 <= 1'b0;
      fdata0  <= q0[0];
   endtask

   task automatic push1(input logic [31:0] w);
      q1.push_back(w);
      fempty1 <= 1'b0;
      fdata1  <= q1[0];
   endtask

   // FWFT FIFO models: pop on rd_en, flag any pop of an empty FIFO.
   always @(posedge clk) begin
      if (rd0) begin
         chk("underflow0", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) void'(q0.pop_front());
      end
      fempty0 <= (q0.size() == 0);
      fdata0  <= (q0.size() != 0) ? q0[0] : 32'h0;
   end

   always @(posedge clk) begin
      if (rd1) begin
         chk("underflow1", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) void'(q1.pop_front());
      end
      fempty1 <= (q1.size() == 0);
      fdata1  <= (q1.size() != 0) ? q1[0] : 32'h0;
   end

   logic [7:0] exp_a[8];
   logic [7:0] exp_b[4];

   initial begin
      fempty0   = 1'b1;
      fempty1   = 1'b1;
      fdata0    = 32'h0;
      fdata1    = 32'h0;
      flush     = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst.rd_en", 32'(rd0), 32'd0);
      chk_beat0("rst", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst.word_cnt", 32'(wc0), 32'd0);

      // Single word LSB-first; first pop only in the second cycle after release
      push0(32'hDEADBEEF);
      rst_n = 1'b1;
      #1 chk("rel.rd_en0", 32'(rd0), 32'd0);
      @(negedge clk);
      chk("t1.rd_en", 32'(rd0), 32'd1);
      chk("t1.valid_pre", 32'(v0), 32'd0);
      exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_beat0($sformatf("t1.b%0d", i), 1'b1, exp_b[i], i == 0, i == 3);
         chk($sformatf("t1.rd%0d", i), 32'(rd0), 32'd0);
      end
      @(negedge clk);
      chk("t1.valid_end", 32'(v0), 32'd0);
      chk("t1.word_cnt", 32'(wc0), 32'd1);

      // Same word MSB-first
      push1(32'hDEADBEEF);
      #1 chk("t2.rd_en", 32'(rd1), 32'd1);
      exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t2.valid%0d", i), 32'(v1), 32'd1);
         chk($sformatf("t2.data%0d", i), 32'(d1), 32'(exp_b[i]));
         chk($sformatf("t2.first%0d", i), 32'(f1), 32'(i == 0));
         chk($sformatf("t2.last%0d", i), 32'(l1), 32'(i == 3));
      end
      @(negedge clk);
      chk("t2.valid_end", 32'(v1), 32'd0);
      chk("t2.word_cnt", 32'(wc1), 32'd1);

      // Two words back-to-back, no bubble
      push0(32'hCAFE0000);
      push0(32'hCAFE0001);
      #1 chk("t3.rd_en", 32'(rd0), 32'd1);
      exp_a = '{8'h00, 8'h00, 8'hFE, 8'hCA, 8'h01, 8'h00, 8'hFE, 8'hCA};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk_beat0($sformatf("t3.b%0d", i), 1'b1, exp_a[i], (i % 4) == 0, (i % 4) == 3);
         chk($sformatf("t3.rd%0d", i), 32'(rd0), 32'(i == 3));
      end
      @(negedge clk);
      chk("t3.valid_end", 32'(v0), 32'd0);
      chk("t3.word_cnt", 32'(wc0), 32'd3);

      // Backpressure on beat 1 with a second word queued
      push0(32'hDEADBEEF);
      push0(32'h01020304);
      #1 chk("t4.rd_en", 32'(rd0), 32'd1);
      @(negedge clk);
      chk_beat0("t4.b0", 1'b1, 8'hEF, 1'b1, 1'b0);
      @(negedge clk);
      chk_beat0("t4.b1", 1'b1, 8'hBE, 1'b0, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("t4.stall_rd%0d", i), 32'(rd0), 32'd0);
         @(negedge clk);
         chk_beat0($sformatf("t4.stall%0d", i), 1'b1, 8'hBE, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk_beat0("t4.b2", 1'b1, 8'hAD, 1'b0, 1'b0);
      @(negedge clk);
      chk_beat0("t4.b3", 1'b1, 8'hDE, 1'b0, 1'b1);
      chk("t4.rd_last", 32'(rd0), 32'd1);
      exp_b = '{8'h04, 8'h03, 8'h02, 8'h01};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_beat0($sformatf("t4.w2b%0d", i), 1'b1, exp_b[i], i == 0, i == 3);
      end
      @(negedge clk);
      chk("t4.valid_end", 32'(v0), 32'd0);
      chk("t4.word_cnt", 32'(wc0), 32'd5);

      // Idle with empty FIFO, including a flush pulse
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("t5.rd%0d", i), 32'(rd0), 32'd0);
         chk($sformatf("t5.valid%0d", i), 32'(v0), 32'd0);
         flush = (i == 10);
      end
      chk("t5.word_cnt", 32'(wc0), 32'd5);

      // Flush mid-word: partial word dropped, next word follows cleanly
      push0(32'h11223344);
      push0(32'h55667788);
      #1 chk("t6.rd_en", 32'(rd0), 32'd1);
      @(negedge clk);
      chk_beat0("t6.b0", 1'b1, 8'h44, 1'b1, 1'b0);
      @(negedge clk);
      chk_beat0("t6.b1", 1'b1, 8'h33, 1'b0, 1'b0);
      flush = 1'b1;
      #1 chk("t6.rd_flush", 32'(rd0), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("t6.valid_flushed", 32'(v0), 32'd0);
      #1 chk("t6.rd_after", 32'(rd0), 32'd1);
      exp_b = '{8'h88, 8'h77, 8'h66, 8'h55};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_beat0($sformatf("t6.n%0d", i), 1'b1, exp_b[i], i == 0, i == 3);
      end
      @(negedge clk);
      chk("t6.valid_end", 32'(v0), 32'd0);
      chk("t6.word_cnt", 32'(wc0), 32'd6);

      // Reset mid-word: asynchronous clear, delayed first pop after release
      push0(32'h11223344);
      push0(32'h55667788);
      @(negedge clk);
      chk_beat0("t7.b0", 1'b1, 8'h44, 1'b1, 1'b0);
      @(negedge clk);
      chk_beat0("t7.b1", 1'b1, 8'h33, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_beat0("t7.rst", 1'b0, 8'h00, 1'b0, 1'b0);
      chk("t7.rst_rd", 32'(rd0), 32'd0);
      chk("t7.rst_cnt", 32'(wc0), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("t7.rel_rd", 32'(rd0), 32'd0);
      @(negedge clk);
      chk("t7.rd2", 32'(rd0), 32'd1);
      chk("t7.valid2", 32'(v0), 32'd0);
      @(negedge clk);
      chk_beat0("t7.n0", 1'b1, 8'h88, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_word_unpacker.md
# fifo_word_unpacker

Downstream consumer for the unified `sync_fifo` when it is built with `FWFT_MODE=1`. It reads IN_WIDTH-bit words from the FIFO head and serialises each word into RATIO = IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready output stream. Typical use is unpacking 32-bit buffered words onto a byte-wide sink. It pops the FIFO with zero bubble between words when the sink never stalls.

## Interface
- IN_WIDTH, 32, FIFO word width. Must equal the FIFO WIDTH.
- OUT_WIDTH, 8, output beat width. IN_WIDTH must be an integer multiple of OUT_WIDTH, with RATIO ≥ 2.
- MSB_FIRST, 0, beat order. 0 emits the least significant slice first; 1 emits the most significant slice first.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous discard of the held word.
- fifo_rd_en  out  1  pop strobe to the FIFO (combinational).
- fifo_rd_data  in  IN_WIDTH  FIFO head word (FWFT, valid while !fifo_empty).
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_data  out  OUT_WIDTH  current beat.
- out_first  out  1  current beat is beat 0 of its word.
- out_last  out  1  current beat is beat RATIO-1 of its word.
- word_cnt  out  16  number of fully emitted words; wraps from 0xFFFF to 0.

## Operation
- State: `run` flag, `hold_valid`, `hold_data[IN_WIDTH]`, `beat_idx[$clog2(RATIO)]`, `word_cnt`.
- Two effective states:
  - EMPTY: `hold_valid`=0.
  - HOLD: `hold_valid`=1, emitting beat `beat_idx`.
- Beat handshake: `bh = out_valid & out_ready`. Word end: `wend = bh & (beat_idx == RATIO-1)`.
- Pop: `fifo_rd_en = run & !flush & !fifo_empty & (!hold_valid | wend)`.
- On pop:
  - `hold_data` ← `fifo_rd_data`.
  - `hold_valid` ← 1.
  - `beat_idx` ← 0.
  - This covers EMPTY→HOLD and HOLD→HOLD back-to-back.
- On `bh` without word end: `beat_idx` increments.
- On `wend`:
  - `word_cnt` increments.
  - If there is no pop in the same cycle, `hold_valid` ← 0 (HOLD→EMPTY).
- Output mapping:
  - `out_valid` = `hold_valid`.
  - `out_first` = `hold_valid & beat_idx==0`.
  - `out_last` = `hold_valid & beat_idx==RATIO-1`.
- Slice selection: slice k = `hold_data[k*OUT_WIDTH +: OUT_WIDTH]`.
  - MSB_FIRST=0: k = `beat_idx`.
  - MSB_FIRST=1: k = RATIO-1-`beat_idx`.
- Stability: while `out_valid` is high and `out_ready` is low, `out_data`, `out_first`, `out_last` are held stable. `out_valid` never falls without a handshake, except on flush or reset.
- flush has highest priority:
  - Next edge: `hold_valid` ← 0 and `beat_idx` ← 0.
  - No pop in the flush cycle.
  - `word_cnt` is unchanged, even if `wend` coincides.
  - The partial word is lost.
- `run` resets to 0 and is set to 1 at the first edge after `rst_n` rises. `fifo_rd_en` is therefore 0 during reset and in the first cycle after release.
- Reset mid-word: the held word is lost. The FIFO is not popped again for it.

## Timing
- Reset values (all outputs):
  - `fifo_rd_en`=0, `out_valid`=0, `out_first`=0, `out_last`=0.
  - `out_data`=0 (`hold_data` resets to 0).
  - `word_cnt`=0.
- Latency:
  - `fifo_rd_en` is high in cycle t (head non-empty, block EMPTY).
  - Beat 0 is presented in cycle t+1.
  - The FIFO head advances at the same edge.
- Throughput with `out_ready` held high: RATIO beats in RATIO consecutive cycles per word.
- Between consecutive words: no idle cycle. `fifo_rd_en` pulses in the same cycle as the `out_last` handshake.
- `fifo_rd_en` is never asserted while `fifo_empty`=1. No underflow pop.
- No state depends on `fifo_rd_data` while `fifo_empty`=1.

## Test plan
- Reset, then FIFO holds 0xDEADBEEF, MSB_FIRST=0, ready high:
  - One `fifo_rd_en` pulse.
  - Next 4 cycles: `out_data` = EF, BE, AD, DE.
  - `out_first` on EF only; `out_last` on DE only.
  - `word_cnt`=1; then `out_valid`=0.
- Same word with MSB_FIRST=1 → `out_data` = DE, AD, BE, EF.
- FIFO holds 0xCAFE0000 and 0xCAFE0001, ready high:
  - 8 valid beats in 8 consecutive cycles: 00,00,FE,CA,01,00,FE,CA.
  - `fifo_rd_en` is high in the cycle of the first CA beat.
  - `word_cnt`=2.
- Backpressure: drop `out_ready` for 3 cycles while beat 1 (BE) is presented.
  - `out_data` stays BE and `out_valid` stays 1.
  - No pop.
  - Stream resumes with AD.
- Empty FIFO for 20 cycles, including one `flush` pulse:
  - `fifo_rd_en`=0 and `out_valid`=0 throughout.
  - `word_cnt` unchanged.
- Mid-word disruptions (0x11223344 after beats 44, 33; next word 0x55667788 queued):
  - Pulse `flush`: `out_valid`=0 next cycle, then 88,77,66,55 follows with `out_first` on 88.
  - Assert `rst_n` low instead: all outputs reset immediately.
  - After release, the first pop occurs no earlier than the second cycle.
